// File: rtl/uart_bus_arbiter.sv
// Two-port arbiter in front of the UART register file: round-robin grant, one-cycle
// UART access, one-cycle response, with an optional bounded lock for back-to-back accesses.
module uart_bus_arbiter #(
    parameter int MAX_LOCK = 4,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              uart_sel,
    output logic              uart_wr_enable,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0] wdata_mem,
    input  logic [DATA_W-1:0] uart_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

    state_t              state_q;
    logic                rr_ptr_q;
    logic                owner_q;
    logic                we_q;
    logic                lock_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [3:0]          burst_cnt_q;

    logic [1:0]          req_v;
    logic [1:0]          lock_v;
    logic [1:0]          we_v;
    logic [ADDR_W-1:0]   addr_v  [2];
    logic [DATA_W-1:0]   wdata_v [2];
    logic [1:0]          idle_gnt;
    logic [1:0]          gnt_v;
    logic [1:0]          rvalid_v;
    logic                cont;
    logic                sel;
    logic                gnt_any;

    assign req_v      = {req1, req0};
    assign lock_v     = {lock1, lock0};
    assign we_v       = {we1, we0};
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;

    // Locked continuation keeps the bus only while the owner still asks and the burst has room.
    assign cont = lock_q & req_v[owner_q] & (burst_cnt_q < MAX_LOCK_C);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign idle_gnt[gi] = req_v[gi] & (~req_v[1-gi] | (rr_ptr_q == 1'(gi)));
            assign gnt_v[gi]    = reset & (((state_q == IDLE) & idle_gnt[gi]) |
                                           ((state_q == RESP) & cont & (owner_q == 1'(gi))));
            assign rvalid_v[gi] = reset & (state_q == RESP) & (owner_q == 1'(gi));
        end
    endgenerate

    assign sel     = (state_q == IDLE) ? idle_gnt[1] : owner_q;
    assign gnt_any = |gnt_v;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            lock_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            if (gnt_any) begin
                owner_q <= sel;
                we_q    <= we_v[sel];
                lock_q  <= lock_v[sel];
                addr_q  <= addr_v[sel];
                wdata_q <= wdata_v[sel];
            end
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        rr_ptr_q    <= ~sel;
                        burst_cnt_q <= 4'd1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= uart_data;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (cont) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                        state_q     <= ACCESS;
                    end else begin
                        burst_cnt_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0           = gnt_v[0];
    assign gnt1           = gnt_v[1];
    assign rvalid0        = rvalid_v[0];
    assign rvalid1        = rvalid_v[1];
    assign rdata          = rdata_q;
    // Strobes are masked while reset is low so an aborted write never reaches the UART.
    assign uart_sel       = reset & (state_q == ACCESS);
    assign uart_wr_enable = uart_sel & we_q;
    assign uart_addr      = addr_q;
    assign wdata_mem      = wdata_q;
    assign busy           = reset & (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: table-driven single accesses plus
// hand-written reset, contention, lock-limit and mid-access reset sequences.
module tb_uart_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
    logic [3:0]  addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, uart_sel, uart_wr_enable, busy;
    logic [31:0] rdata, wdata_mem, uart_data;
    logic [3:0]  uart_addr;

    uart_bus_arbiter #(.MAX_LOCK(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .uart_sel(uart_sel), .uart_wr_enable(uart_wr_enable),
        .uart_addr(uart_addr), .wdata_mem(wdata_mem), .uart_data(uart_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Simple UART register file model: combinational read, write on strobe.
    logic [31:0] uart_regs [16];
    logic        uart_init = 1'b1;
    always @(posedge clock) begin
        if (uart_init) begin
            for (int i = 0; i < 16; i++) uart_regs[i] <= 32'h1000_0000 + i;
            uart_regs[4] <= 32'h0000_00A5;
        end else if (uart_sel && uart_wr_enable) begin
            uart_regs[uart_addr] <= wdata_mem;
        end
    end
    assign uart_data = uart_regs[uart_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { bit port; bit we; logic [31:0] rd; } sb_t;
    typedef struct { bit port; int c; } gr_t;
    typedef struct { bit port; bit we; logic [3:0] addr; logic [31:0] wdata; logic [31:0] exp_rdata; } vec_t;

    sb_t         sbq[$];
    gr_t         grq[$];
    logic [31:0] rdata_model = 32'h0;
    logic [31:0] exp_rd [2];
    vec_t        vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req_v);
        end
    endtask

    // Called once per cycle once inputs have settled: pops completions, pushes grants.
    task automatic sample_cycle();
        sb_t         e;
        logic [31:0] ev;
        chk("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'h0);
        chk("rvalid_exclusive", {31'b0, rvalid0 & rvalid1}, 32'h0);
        if (rvalid0 || rvalid1) begin
            if (sbq.size() == 0) begin
                chk("rvalid_unexpected", 32'h1, 32'h0);
            end else begin
                e  = sbq.pop_front();
                ev = e.we ? rdata_model : e.rd;
                chk("rvalid_port", {31'b0, rvalid1}, {31'b0, e.port});
                chk("rdata", rdata, ev);
                rdata_model = ev;
            end
        end
        if (gnt0 || gnt1) begin
            sbq.push_back('{port: gnt1, we: (gnt1 ? we1 : we0), rd: exp_rd[gnt1]});
            grq.push_back('{port: gnt1, c: cyc});
        end
    endtask

    task automatic cyc_run(input int n);
        repeat (n) begin
            @(posedge clock); #2;
            sample_cycle();
        end
    endtask

    task automatic drive_port(input bit p, input bit r, input bit l, input bit w,
                              input logic [3:0] a, input logic [31:0] d);
        if (p) begin req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 4'h4, 32'h0,         32'h0000_00A5};
        vecs[1] = '{1, 1, 4'h0, 32'h55,        32'h0000_00A5};
        vecs[2] = '{0, 0, 4'h0, 32'h0,         32'h0000_0055};
        vecs[3] = '{1, 1, 4'h9, 32'h1234_5678, 32'h0000_0055};
        vecs[4] = '{1, 0, 4'h9, 32'h0,         32'h1234_5678};
        vecs[5] = '{0, 0, 4'hF, 32'h0,         32'h1000_000F};
        vecs[6] = '{0, 1, 4'hF, 32'hFFFF_FFFF, 32'h1000_000F};
        vecs[7] = '{0, 0, 4'hF, 32'h0,         32'hFFFF_FFFF};
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;

        // Reset held with both ports requesting.
        req0 = 1; req1 = 1; addr0 = 4'h2; addr1 = 4'h3;
        @(posedge clock); #1; uart_init = 1'b0;
        repeat (3) begin
            @(posedge clock); #2;
            chk("rst_gnt", {30'b0, gnt1, gnt0}, 32'h0);
            chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
            chk("rst_uart_sel", {30'b0, uart_wr_enable, uart_sel}, 32'h0);
            chk("rst_busy_rdata", rdata | {31'b0, busy}, 32'h0);
        end
        reset = 1'b1; exp_rd[0] = 32'h1000_0002; exp_rd[1] = 32'h1000_0003; #1;
        chk("first_gnt_port0", {30'b0, gnt1, gnt0}, 32'h1);
        sample_cycle();
        @(posedge clock); #1; req0 = 0; req1 = 0; #1; sample_cycle();
        cyc_run(2);
        chk("post_first_idle", {31'b0, busy}, 32'h0);

        // Table of single accesses from an idle bus.
        for (int i = 0; i < 8; i++) begin
            exp_rd[vecs[i].port] = vecs[i].exp_rdata;
            drive_port(vecs[i].port, 1, 0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            chk("tbl_gnt", {30'b0, gnt1, gnt0}, vecs[i].port ? 32'h2 : 32'h1);
            sample_cycle();
            @(posedge clock); #1;
            drive_port(vecs[i].port, 0, 0, 0, 4'h0, 32'h0);
            #1;
            sample_cycle();
            chk("tbl_access_sel", {31'b0, uart_sel}, 32'h1);
            chk("tbl_access_we", {31'b0, uart_wr_enable}, {31'b0, vecs[i].we});
            chk("tbl_access_addr", {28'b0, uart_addr}, {28'b0, vecs[i].addr});
            if (vecs[i].we) chk("tbl_access_wdata", wdata_mem, vecs[i].wdata);
            @(posedge clock); #2;
            sample_cycle();
            chk("tbl_rvalid", {30'b0, rvalid1, rvalid0}, vecs[i].port ? 32'h2 : 32'h1);
            chk("tbl_rdata", rdata, vecs[i].exp_rdata);
            chk("tbl_resp_strobes", {30'b0, uart_wr_enable, uart_sel}, 32'h0);
            @(posedge clock); #2;
            sample_cycle();
            chk("tbl_idle", {29'b0, busy, rvalid1, rvalid0}, 32'h0);
        end

        // Contention without lock: last table grant was port 0, so port 1 leads.
        grq.delete();
        exp_rd[0] = 32'h1000_0002; exp_rd[1] = 32'h1000_0003;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 4'h2; addr1 = 4'h3;
        #1; sample_cycle();
        cyc_run(11);
        @(posedge clock); #1; req0 = 0; req1 = 0; #1; sample_cycle();
        cyc_run(2);
        chk("cont_count", grq.size(), 4);
        for (int i = 0; i < grq.size() && i < 4; i++) begin
            chk("cont_port", {31'b0, grq[i].port}, (i % 2 == 0) ? 32'h1 : 32'h0);
            if (i > 0) chk("cont_spacing", grq[i].c - grq[i-1].c, 3);
        end

        // Lock limit: port 0 bursts MAX_LOCK accesses, then port 1 gets the bus.
        grq.delete();
        exp_rd[0] = 32'h1000_0005; exp_rd[1] = 32'h1000_0006;
        req0 = 1; lock0 = 1; we0 = 0; addr0 = 4'h5;
        we1 = 0; addr1 = 4'h6; lock1 = 0;
        #1; sample_cycle();
        @(posedge clock); #1; req1 = 1; #1; sample_cycle();
        cyc_run(8);
        @(posedge clock); #1; req0 = 0; lock0 = 0; req1 = 0; #1; sample_cycle();
        cyc_run(3);
        chk("lock_count", grq.size(), 5);
        for (int i = 0; i < grq.size() && i < 5; i++) begin
            chk("lock_port", {31'b0, grq[i].port}, (i == 4) ? 32'h1 : 32'h0);
            if (i > 0) chk("lock_spacing", grq[i].c - grq[i-1].c, (i == 4) ? 3 : 2);
        end
        chk("lock_sb_empty", sbq.size(), 0);

        // Reset during the ACCESS cycle of a write: no completion, no UART write.
        drive_port(1, 1, 0, 1, 4'h7, 32'hDEAD_BEEF);
        #1; sample_cycle();
        chk("abort_gnt", {30'b0, gnt1, gnt0}, 32'h2);
        @(posedge clock); #1;
        reset = 0; drive_port(1, 0, 0, 0, 4'h0, 32'h0);
        #1;
        chk("abort_strobes", {30'b0, uart_wr_enable, uart_sel}, 32'h0);
        sbq.delete();
        @(posedge clock); #1; reset = 1; #1;
        chk("abort_idle", {28'b0, busy, uart_sel, rvalid1, rvalid0}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_uart_reg", uart_regs[7], 32'h1000_0007);
        rdata_model = 32'h0;
        cyc_run(3);
        chk("abort_no_rvalid_end", {29'b0, busy, rvalid1, rvalid0}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
